hand_feature_extractor: RTL and testbench
=========================================

# hand_feature_extractor

Consumes the binary hand mask produced by the serial HSV capture stage and reduces it to a compact feature vector: hand pixel count, bounding box, and row/column moment sums. It sits directly downstream of the capture stage, in the debounced `slow_clk` domain. It starts a scan when `image_ready` rises and holds the result under a valid/ready handshake for the classifier stage.

## Interface
- `LENGTH`, 28, image rows; row index width is 5 bits.
- `WIDTH`, 28, image columns; column index width is 5 bits.
- `slow_clk`  in  1  block clock.
- `dbnc_rst`  in  1  reset, asynchronous, active-high.
- `filtered_image`  in  [LENGTH-1:0][WIDTH-1:0]  hand mask; `[r][c]`=1 marks a hand pixel.
- `image_ready`  in  1  level; high while the mask is complete.
- `feat_ready`  in  1  consumer accepts the result.
- `feat_valid`  out  1  result registers are valid and stable.
- `busy`  out  1  high in SCAN.
- `empty`  out  1  completed scan found zero hand pixels.
- `pixel_count`  out  10  number of hand pixels.
- `row_min`, `row_max`, `col_min`, `col_max`  out  5 each  bounding box, inclusive.
- `row_sum`, `col_sum`  out  15 each  sum of row (column) index over all hand pixels.

## Operation
- Rise detector: `rdy_q` is registered `image_ready`. Start when `image_ready && !rdy_q`. The detector updates in every state.
- States:
  - IDLE: on start go to SCAN. In the same edge, snapshot `filtered_image` into an internal LENGTH*WIDTH register, set scan indices to r=0, c=0, and clear the accumulators. Accumulators are count=0, sums=0, min=5'h1F, max=0.
  - SCAN: each cycle, process snapshot pixel [r][c] in row-major order.
    - If the pixel is 1: count+=1, row_sum+=r, col_sum+=c, update min/max.
    - Advance c. When c==WIDTH-1, set c=0 and r+=1.
    - On the last pixel (r==LENGTH-1, c==WIDTH-1), the accumulators take that pixel's update. In the same edge, load the output registers and go to DONE.
  - DONE: `feat_valid`=1 and all outputs are frozen. When `feat_valid && feat_ready` is sampled, go to IDLE.
- Output load rules:
  - `empty` = (count==0).
  - If empty, all bbox outputs are 0. Otherwise the bbox outputs take the min/max accumulators.
- Start edges seen in SCAN or DONE are ignored and not queued.
- The snapshot isolates the scan from upstream changes to the mask during SCAN.
- Width rules:
  - `pixel_count` reaches at most 784 at defaults, so 10 bits suffice.
  - `row_sum` and `col_sum` reach at most 27*784 = 21168, so 15 bits suffice; they never wrap at defaults.
  - The accumulators are the same width as their outputs.

## Timing
- Reset values (async, immediate): state IDLE, `rdy_q`=0, `feat_valid`=0, `busy`=0, `empty`=0, all feature outputs 0, snapshot 0.
- Rising edge E0 samples the start condition. `busy`=1 after E0.
- With N = LENGTH*WIDTH (784 at defaults), pixel k (0-based) is processed at edge E(k+1).
- `feat_valid`=1 and `busy`=0 after edge EN. Total latency is N cycles from E0.
- Handshake:
  - `feat_valid` drops the cycle after the edge that samples `feat_ready`=1.
  - With `feat_ready` held high, `feat_valid` is a one-cycle pulse.
  - The earliest next start-edge sample is the edge after returning to IDLE.
- If `image_ready` is already high when reset releases, the first edge counts as a rise and a scan starts.
- Reset mid-SCAN or mid-DONE aborts the scan. No partial result is ever presented. The next rise runs a full fresh scan.

## Test plan
- Reset check: assert `dbnc_rst` mid-run -> all outputs 0 at once; `feat_valid`=0 until a new rise plus 784 cycles.
- Empty mask, rise `image_ready` -> `feat_valid` exactly 784 cycles after the start edge. Result: `empty`=1, `pixel_count`=0, bbox 0, sums 0. All-ones mask -> count 784, bbox 0..27, `row_sum`=`col_sum`=10584.
- Single pixel [5][14] -> count 1, rows 5/5, cols 14/14, `row_sum`=5, `col_sum`=14, `empty`=0.
- Rectangle rows 6..16 x cols 14..17 -> count 44, `row_min`=6, `row_max`=16, `col_min`=14, `col_max`=17, `row_sum`=484, `col_sum`=682.
- Backpressure and isolation, using the rectangle mask:
  - Hold `feat_ready`=0 for 10 cycles and toggle `image_ready` during DONE -> outputs stable, no restart.
  - Raise `feat_ready` -> `feat_valid` falls the next cycle.
  - Change the mask mid-SCAN -> result still matches the snapshot.
- Reset at scan cycle 300 -> outputs 0. Then re-rise with the single-pixel mask -> correct result 784 cycles later.

Source files
------------

// File: rtl/hand_feature_extractor.sv
// Hand feature extractor: snapshots a binary hand mask on the rising edge of
// image_ready, scans it one pixel per cycle in row-major order and presents
// pixel count, bounding box and row/column moment sums under valid/ready.
module hand_feature_extractor #(
  parameter int unsigned LENGTH = 28,
  parameter int unsigned WIDTH  = 28
) (
  input  logic                           slow_clk,
  input  logic                           dbnc_rst,
  input  logic [LENGTH-1:0][WIDTH-1:0]   filtered_image,
  input  logic                           image_ready,
  input  logic                           feat_ready,
  output logic                           feat_valid,
  output logic                           busy,
  output logic                           empty,
  output logic [9:0]                     pixel_count,
  output logic [4:0]                     row_min,
  output logic [4:0]                     row_max,
  output logic [4:0]                     col_min,
  output logic [4:0]                     col_max,
  output logic [14:0]                    row_sum,
  output logic [14:0]                    col_sum
);

  localparam int unsigned IdxW = 5;
  localparam int unsigned CntW = 10;
  localparam int unsigned SumW = 15;

  localparam logic [IdxW-1:0] RowLast = IdxW'(LENGTH - 1);
  localparam logic [IdxW-1:0] ColLast = IdxW'(WIDTH - 1);
  localparam logic [IdxW-1:0] MinInit = '1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e state_q, state_d;
  logic   rdy_q;
  logic   start;

  logic [LENGTH-1:0][WIDTH-1:0] snap_q, snap_d;
  logic [IdxW-1:0] r_q, r_d, c_q, c_d;

  // Running accumulators
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SumW-1:0] rsum_q, rsum_d, csum_q, csum_d;
  logic [IdxW-1:0] rmin_q, rmin_d, rmax_q, rmax_d, cmin_q, cmin_d, cmax_q, cmax_d;

  // Accumulators with the current pixel folded in
  logic            pix;
  logic [CntW-1:0] cnt_upd;
  logic [SumW-1:0] rsum_upd, csum_upd;
  logic [IdxW-1:0] rmin_upd, rmax_upd, cmin_upd, cmax_upd;
  logic            last_pix;

  // Result registers, frozen outside the final scan edge
  logic            empty_q, empty_d;
  logic [CntW-1:0] pcnt_q, pcnt_d;
  logic [IdxW-1:0] orow_min_q, orow_min_d, orow_max_q, orow_max_d;
  logic [IdxW-1:0] ocol_min_q, ocol_min_d, ocol_max_q, ocol_max_d;
  logic [SumW-1:0] orow_sum_q, orow_sum_d, ocol_sum_q, ocol_sum_d;

  assign start = image_ready && !rdy_q;

  // Rise detector on image_ready, active in every state
  always_ff @(posedge slow_clk or posedge dbnc_rst) begin
    if (dbnc_rst) rdy_q <= 1'b0;
    else          rdy_q <= image_ready;
  end

  // State, snapshot, scan indices and accumulators
  always_ff @(posedge slow_clk or posedge dbnc_rst) begin
    if (dbnc_rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      rsum_q  <= '0;
      csum_q  <= '0;
      rmin_q  <= MinInit;
      rmax_q  <= '0;
      cmin_q  <= MinInit;
      cmax_q  <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      rsum_q  <= rsum_d;
      csum_q  <= csum_d;
      rmin_q  <= rmin_d;
      rmax_q  <= rmax_d;
      cmin_q  <= cmin_d;
      cmax_q  <= cmax_d;
    end
  end

  // Result registers
  always_ff @(posedge slow_clk or posedge dbnc_rst) begin
    if (dbnc_rst) begin
      empty_q    <= 1'b0;
      pcnt_q     <= '0;
      orow_min_q <= '0;
      orow_max_q <= '0;
      ocol_min_q <= '0;
      ocol_max_q <= '0;
      orow_sum_q <= '0;
      ocol_sum_q <= '0;
    end else begin
      empty_q    <= empty_d;
      pcnt_q     <= pcnt_d;
      orow_min_q <= orow_min_d;
      orow_max_q <= orow_max_d;
      ocol_min_q <= ocol_min_d;
      ocol_max_q <= ocol_max_d;
      orow_sum_q <= orow_sum_d;
      ocol_sum_q <= ocol_sum_d;
    end
  end

  // Fold the current snapshot pixel into the accumulators
  always_comb begin
    pix      = snap_q[r_q][c_q];
    cnt_upd  = cnt_q;
    rsum_upd = rsum_q;
    csum_upd = csum_q;
    rmin_upd = rmin_q;
    rmax_upd = rmax_q;
    cmin_upd = cmin_q;
    cmax_upd = cmax_q;
    if (pix) begin
      cnt_upd  = cnt_q + CntW'(1);
      rsum_upd = rsum_q + SumW'(r_q);
      csum_upd = csum_q + SumW'(c_q);
      if (r_q < rmin_q) rmin_upd = r_q;
      if (r_q > rmax_q) rmax_upd = r_q;
      if (c_q < cmin_q) cmin_upd = c_q;
      if (c_q > cmax_q) cmax_upd = c_q;
    end
    last_pix = (r_q == RowLast) && (c_q == ColLast);
  end

  // Next-state logic for the scan FSM and result load
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    r_d        = r_q;
    c_d        = c_q;
    cnt_d      = cnt_q;
    rsum_d     = rsum_q;
    csum_d     = csum_q;
    rmin_d     = rmin_q;
    rmax_d     = rmax_q;
    cmin_d     = cmin_q;
    cmax_d     = cmax_q;
    empty_d    = empty_q;
    pcnt_d     = pcnt_q;
    orow_min_d = orow_min_q;
    orow_max_d = orow_max_q;
    ocol_min_d = ocol_min_q;
    ocol_max_d = ocol_max_q;
    orow_sum_d = orow_sum_q;
    ocol_sum_d = ocol_sum_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StScan;
          snap_d  = filtered_image;
          r_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          rsum_d  = '0;
          csum_d  = '0;
          rmin_d  = MinInit;
          rmax_d  = '0;
          cmin_d  = MinInit;
          cmax_d  = '0;
        end
      end
      StScan: begin
        cnt_d  = cnt_upd;
        rsum_d = rsum_upd;
        csum_d = csum_upd;
        rmin_d = rmin_upd;
        rmax_d = rmax_upd;
        cmin_d = cmin_upd;
        cmax_d = cmax_upd;
        if (c_q == ColLast) begin
          c_d = '0;
          r_d = r_q + IdxW'(1);
        end else begin
          c_d = c_q + IdxW'(1);
        end
        if (last_pix) begin
          r_d        = '0;
          state_d    = StDone;
          empty_d    = (cnt_upd == '0);
          pcnt_d     = cnt_upd;
          orow_sum_d = rsum_upd;
          ocol_sum_d = csum_upd;
          // An empty mask would leave min at all-ones; report a zero box instead
          orow_min_d = empty_d ? '0 : rmin_upd;
          orow_max_d = empty_d ? '0 : rmax_upd;
          ocol_min_d = empty_d ? '0 : cmin_upd;
          ocol_max_d = empty_d ? '0 : cmax_upd;
        end
      end
      StDone: begin
        if (feat_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy        = (state_q == StScan);
  assign feat_valid  = (state_q == StDone);
  assign empty       = empty_q;
  assign pixel_count = pcnt_q;
  assign row_min     = orow_min_q;
  assign row_max     = orow_max_q;
  assign col_min     = ocol_min_q;
  assign col_max     = ocol_max_q;
  assign row_sum     = orow_sum_q;
  assign col_sum     = ocol_sum_q;

endmodule

// File: tb/tb_hand_feature_extractor.sv
// Self-checking bench for hand_feature_extractor: directed and random masks
// checked against a loop-based feature model.
module tb_hand_feature_extractor;

  localparam int L = 28;
  localparam int W = 28;
  localparam int N = L * W;

  typedef logic [L-1:0][W-1:0] mask_t;

  typedef struct {
    int cnt;
    int rs;
    int cs;
    int rmin;
    int rmax;
    int cmin;
    int cmax;
    int emp;
  } feat_t;

  logic        slow_clk;
  logic        dbnc_rst;
  mask_t       filtered_image;
  logic        image_ready;
  logic        feat_ready;
  logic        feat_valid;
  logic        busy;
  logic        empty;
  logic [9:0]  pixel_count;
  logic [4:0]  row_min;
  logic [4:0]  row_max;
  logic [4:0]  col_min;
  logic [4:0]  col_max;
  logic [14:0] row_sum;
  logic [14:0] col_sum;

  int checks = 0;
  int errors = 0;

  hand_feature_extractor #(
    .LENGTH(L),
    .WIDTH (W)
  ) dut (
    .slow_clk      (slow_clk),
    .dbnc_rst      (dbnc_rst),
    .filtered_image(filtered_image),
    .image_ready   (image_ready),
    .feat_ready    (feat_ready),
    .feat_valid    (feat_valid),
    .busy          (busy),
    .empty         (empty),
    .pixel_count   (pixel_count),
    .row_min       (row_min),
    .row_max       (row_max),
    .col_min       (col_min),
    .col_max       (col_max),
    .row_sum       (row_sum),
    .col_sum       (col_sum)
  );

  initial slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Features straight from the definition: count, bounding box, index sums
  function automatic feat_t model(input mask_t m);
    feat_t f;
    f.cnt = 0; f.rs = 0; f.cs = 0;
    f.rmin = L; f.rmax = -1; f.cmin = W; f.cmax = -1;
    for (int r = 0; r < L; r++) begin
      for (int c = 0; c < W; c++) begin
        if (m[r][c]) begin
          f.cnt++;
          f.rs += r;
          f.cs += c;
          if (r < f.rmin) f.rmin = r;
          if (r > f.rmax) f.rmax = r;
          if (c < f.cmin) f.cmin = c;
          if (c > f.cmax) f.cmax = c;
        end
      end
    end
    f.emp = (f.cnt == 0) ? 1 : 0;
    if (f.emp == 1) begin
      f.rmin = 0; f.rmax = 0; f.cmin = 0; f.cmax = 0;
    end
    return f;
  endfunction

  function automatic mask_t make_rect(input int r0, input int r1, input int c0, input int c1);
    mask_t m = '0;
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++) m[r][c] = 1'b1;
    return m;
  endfunction

  function automatic mask_t rand_mask();
    mask_t m;
    for (int r = 0; r < L; r++) m[r] = W'($urandom() & $urandom());
    return m;
  endfunction

  task automatic check_feat(input feat_t e);
    check("empty", {31'd0, empty}, e.emp);
    check("pixel_count", {22'd0, pixel_count}, e.cnt);
    check("row_min", {27'd0, row_min}, e.rmin);
    check("row_max", {27'd0, row_max}, e.rmax);
    check("col_min", {27'd0, col_min}, e.cmin);
    check("col_max", {27'd0, col_max}, e.cmax);
    check("row_sum", {17'd0, row_sum}, e.rs);
    check("col_sum", {17'd0, col_sum}, e.cs);
  endtask

  task automatic check_zero();
    check("rst_feat_valid", {31'd0, feat_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_empty", {31'd0, empty}, 0);
    check("rst_pixel_count", {22'd0, pixel_count}, 0);
    check("rst_bbox", {12'd0, row_min, row_max, col_min, col_max}, 0);
    check("rst_sums", {2'd0, row_sum, col_sum}, 0);
  endtask

  // image_ready must be high at the next posedge (E0). Returns edges from E0
  // to feat_valid; the mask is scrambled after edge scramble_at if nonzero.
  task automatic wait_valid(input int scramble_at, output int lat);
    lat = 0;
    @(posedge slow_clk);
    @(negedge slow_clk);
    check("busy_after_e0", {31'd0, busy}, 1);
    image_ready = 1'b0;
    for (int i = 1; i <= N + 100; i++) begin
      @(negedge slow_clk);
      if (i == scramble_at) filtered_image = rand_mask();
      if (feat_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_scan(input mask_t m, input int scramble_at, output feat_t e);
    int lat;
    filtered_image = m;
    e = model(m);
    @(negedge slow_clk);
    image_ready = 1'b1;
    wait_valid(scramble_at, lat);
    check("latency", lat, N);
    check("busy_in_done", {31'd0, busy}, 0);
    check_feat(e);
  endtask

  task automatic accept();
    feat_ready = 1'b1;
    @(negedge slow_clk);
    check("valid_drop", {31'd0, feat_valid}, 0);
    feat_ready = 1'b0;
  endtask

  initial begin
    feat_t e;
    int    lat;
    dbnc_rst       = 1'b1;
    image_ready    = 1'b0;
    feat_ready     = 1'b0;
    filtered_image = '0;
    repeat (2) @(negedge slow_clk);
    check_zero();
    dbnc_rst = 1'b0;
    @(negedge slow_clk);

    // Empty mask, feat_ready held high: one-cycle valid pulse
    feat_ready = 1'b1;
    run_scan('0, 0, e);
    check("empty_const", {31'd0, empty}, 1);
    accept();

    // All-ones mask
    run_scan('1, 0, e);
    check("ones_row_sum", {17'd0, row_sum}, 10584);
    accept();

    // Single pixel [5][14]
    e = model('0);
    begin
      mask_t m = '0;
      m[5][14] = 1'b1;
      run_scan(m, 0, e);
    end
    check("single_rmin", {27'd0, row_min}, 5);
    accept();

    // Rectangle, mask changed mid-scan, then backpressure with image_ready toggling
    run_scan(make_rect(6, 16, 14, 17), 400, e);
    check("rect_row_sum", {17'd0, row_sum}, 484);
    check("rect_col_sum", {17'd0, col_sum}, 682);
    for (int i = 0; i < 10; i++) begin
      image_ready = ~image_ready;
      @(negedge slow_clk);
      check("bp_valid", {31'd0, feat_valid}, 1);
      check("bp_busy", {31'd0, busy}, 0);
      check_feat(e);
    end
    image_ready = 1'b0;
    @(negedge slow_clk);
    accept();
    repeat (3) begin
      @(negedge slow_clk);
      check("no_restart", {30'd0, busy, feat_valid}, 0);
    end

    // Random masks and rectangles, one with a mid-scan scramble
    for (int t = 0; t < 4; t++) begin
      run_scan(rand_mask(), (t == 1) ? 300 : 0, e);
      accept();
    end
    for (int t = 0; t < 2; t++) begin
      int r0 = $urandom_range(0, L - 1);
      int r1 = $urandom_range(r0, L - 1);
      int c0 = $urandom_range(0, W - 1);
      int c1 = $urandom_range(c0, W - 1);
      run_scan(make_rect(r0, r1, c0, c1), 0, e);
      accept();
    end

    // Reset at scan cycle 300 with a nonzero previous result on the outputs
    filtered_image = make_rect(6, 16, 14, 17);
    @(negedge slow_clk);
    image_ready = 1'b1;
    @(posedge slow_clk);
    @(negedge slow_clk);
    image_ready = 1'b0;
    repeat (299) @(negedge slow_clk);
    check("pre_rst_busy", {31'd0, busy}, 1);
    image_ready = 1'b1;
    dbnc_rst    = 1'b1;
    #1;
    check_zero();
    filtered_image = '0;
    filtered_image[5][14] = 1'b1;
    e = model(filtered_image);
    repeat (2) @(negedge slow_clk);
    check("rst_hold_valid", {31'd0, feat_valid}, 0);
    // image_ready already high at release: the first edge is a start
    dbnc_rst = 1'b0;
    wait_valid(0, lat);
    check("rst_restart_latency", lat, N);
    check_feat(e);
    accept();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
